voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Polyphony scheduler: shares NUM_VOICES square-wave generator voices among NUM_NOTES note gates
//  (keys/switches or sequencer gates). Each voice is driven by (voice_play, voice_period, voice_trig).
//  Allocates a free voice on note press and frees it on release; when all voices are busy, steals the
//  oldest allocation. Sits between the gate mux and the Wave_Generator bank, ahead of the mixer.
// PARAMETERS
//  NUM_NOTES   8   number of note gate requesters (max 16)
//  NUM_VOICES  4   number of physical oscillator voices (2..8)
//  PERIOD_W    32  width of a half-cycle period count, in CLOCK_50 ticks
// PORTS
//  clock         in   1                      system clock (50 MHz)
//  reset         in   1                      synchronous, active-high
//  note_gate     in   NUM_NOTES              level request per note; 1 = held
//  note_period   in   NUM_NOTES*PERIOD_W     period table; note n at [n*PERIOD_W +: PERIOD_W]
//  voice_play    out  NUM_VOICES             voice v sounding
//  voice_period  out  NUM_VOICES*PERIOD_W    period latched at allocation, per voice
//  voice_note    out  NUM_VOICES*4           note index owned by voice v; valid only when play=1
//  voice_trig    out  NUM_VOICES             1-cycle pulse: voice (re)assigned, generator restarts phase
//  steal_pulse   out  1                      1-cycle pulse: an allocation stole a busy voice
//  busy          out  1                      any press/release event pending
// BEHAVIOUR
//  - Reset: voice_play=0, voice_period=0, voice_note=0, voice_trig=0, steal_pulse=0, busy=0;
//    ack[]=0 and age ranks rank[v]=v. Reset mid-operation drops all voices within one cycle.
//  - note_gate is registered once (gate_q). ack[n] = note n has been accepted.
//    Press event: gate_q[n] & ~ack[n]. Release event: ~gate_q[n] & ack[n]. Level-based, so a glitch
//    shorter than the service delay produces no event; a note held through reset is re-accepted.
//  - One event served per cycle. Priority: any release over any press; lowest note index first.
//    busy = OR of all pending events (combinational from gate_q/ack).
//  - Latency: gate changes before edge k -> gate_q at k -> served, outputs registered at edge k+1
//    (when no older events are queued). Each queued event adds one cycle.
//  - Serve release n: ack[n]<=0. If a voice v has play=1 and note=n: play[v]<=0; rank unchanged.
//    If note n was stolen (owns no voice): only ack is cleared.
//  - Serve press n: ack[n]<=1. Target = lowest-index voice with play=0; otherwise the voice with
//    rank 0 (oldest), with steal_pulse<=1. Target: play<=1, note<=n, period<=note_period[n],
//    trig<=1. Ages: voices with rank > rank[target] decrement; rank[target]<=NUM_VOICES-1.
//    A stolen note keeps ack=1 and is not re-allocated until released and pressed again.
//  - voice_trig/steal_pulse are 0 in every cycle that does not serve a press.
//  - Period change on note_period while sounding is ignored until the next allocation.
//  - Ranks stay a permutation of 0..NUM_VOICES-1 at all times (assertion).
//  - No two playing voices share a note index (assertion).
// STRUCTURE
//  - Shared package audio_pkg: PERIOD_W, NOTE_IDX_W=4, note period constants (C=191109,
//    D=170265, E=151685, F=143172, G=127551, A=113636, B=101239, C1=95556).
//  - Sub-module voice_age_tracker: holds rank[], takes (alloc_en, alloc_voice) and outputs
//    oldest_voice. Top level holds gate_q/ack, event priority encoder, and voice output registers.
// TESTING
//  1 note 2 high (period 151685) from idle -> 2 edges later voice0 play=1, note=2, period=151685;
//    trig[0] high exactly 1 cycle; busy high 1 cycle; steal_pulse=0.
//  2 press notes 0,1,2,3 one at a time, then note 4 -> voice0 (oldest) becomes note 4, play stays 1,
//    steal_pulse=1, trig[0]=1; releasing note 0 afterwards changes no voice output.
//  3 notes 1,5,7 rise in the same cycle -> served on 3 consecutive edges to voices 0,1,2 in that order;
//    busy high for 3 cycles.
//  4 all 4 voices busy; note 0 falls and note 6 rises same cycle -> release served first, note 6 takes
//    voice0 one cycle later, steal_pulse stays 0.
//  5 note 3 pulsed high for 1 cycle while 3 older events queued -> no allocation, no trig.
//  6 reset for 1 cycle mid-play with notes 0,2 held -> all outputs 0 after reset; after deassertion,
//    notes 0,2 reallocated to voices 0,1 on successive edges.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants: period width, note index width, note period table
// and the event record used by the voice allocator.
package audio_pkg;

  localparam int unsigned PERIOD_W   = 32;
  localparam int unsigned NOTE_IDX_W = 4;

  // Half-cycle periods in 50 MHz ticks, one octave C..C1
  localparam logic [PERIOD_W-1:0] PERIOD_C  = PERIOD_W'(191109);
  localparam logic [PERIOD_W-1:0] PERIOD_D  = PERIOD_W'(170265);
  localparam logic [PERIOD_W-1:0] PERIOD_E  = PERIOD_W'(151685);
  localparam logic [PERIOD_W-1:0] PERIOD_F  = PERIOD_W'(143172);
  localparam logic [PERIOD_W-1:0] PERIOD_G  = PERIOD_W'(127551);
  localparam logic [PERIOD_W-1:0] PERIOD_A  = PERIOD_W'(113636);
  localparam logic [PERIOD_W-1:0] PERIOD_B  = PERIOD_W'(101239);
  localparam logic [PERIOD_W-1:0] PERIOD_C1 = PERIOD_W'(95556);

  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_RELEASE = 2'd1,
    EV_PRESS   = 2'd2
  } event_kind_e;

  typedef struct packed {
    event_kind_e            kind;
    logic [NOTE_IDX_W-1:0]  note;
  } note_event_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Allocation-age ranking of the voices; rank 0 is the oldest allocation
// and is the steal candidate when no voice is free.
module voice_age_tracker
  import audio_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alloc_en_i,
  input  logic [$clog2(NUM_VOICES)-1:0] alloc_voice_i,
  output logic [$clog2(NUM_VOICES)-1:0] oldest_voice_o
);

  localparam int unsigned VOICE_W = $clog2(NUM_VOICES);

  logic [VOICE_W-1:0]    rank_q [NUM_VOICES];
  logic [VOICE_W-1:0]    rank_d [NUM_VOICES];
  logic [VOICE_W-1:0]    oldest_q;
  logic [VOICE_W-1:0]    oldest_d;
  logic [NUM_VOICES-1:0] rank_seen;

  // Newest allocation moves to the top; everything younger than it shifts down
  always_comb begin
    rank_d   = rank_q;
    oldest_d = '0;
    if (alloc_en_i) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (VOICE_W'(v) == alloc_voice_i) begin
          rank_d[v] = VOICE_W'(NUM_VOICES - 1);
        end else if (rank_q[v] > rank_q[alloc_voice_i]) begin
          rank_d[v] = rank_q[v] - VOICE_W'(1);
        end
      end
    end
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (rank_d[v] == '0) oldest_d = VOICE_W'(v);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) rank_q[v] <= VOICE_W'(v);
      oldest_q <= '0;
    end else begin
      rank_q   <= rank_d;
      oldest_q <= oldest_d;
    end
  end

  assign oldest_voice_o = oldest_q;

  always_comb begin
    rank_seen = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) rank_seen[rank_q[v]] = 1'b1;
  end

  rank_permutation: assert property (@(posedge clock) disable iff (reset) &rank_seen);

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: serves one note press/release per cycle, assigning
// note gates to oscillator voices and stealing the oldest voice when full.
module voice_allocator
  import audio_pkg::*;
#(
  parameter int unsigned NUM_NOTES  = 8,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PERIOD_W   = audio_pkg::PERIOD_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_NOTES-1:0]             note_gate,
  input  logic [NUM_NOTES*PERIOD_W-1:0]    note_period,
  output logic [NUM_VOICES-1:0]            voice_play,
  output logic [NUM_VOICES*PERIOD_W-1:0]   voice_period,
  output logic [NUM_VOICES*NOTE_IDX_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]            voice_trig,
  output logic                             steal_pulse,
  output logic                             busy
);

  localparam int unsigned VOICE_W = $clog2(NUM_VOICES);

  logic [NUM_NOTES-1:0]   gate_q;
  logic [NUM_NOTES-1:0]   ack_q, ack_d;
  logic [NUM_VOICES-1:0]  play_q, play_d;
  logic [NUM_VOICES-1:0]  trig_q, trig_d;
  logic                   steal_q, steal_d;
  logic [NOTE_IDX_W-1:0]  note_q   [NUM_VOICES];
  logic [NOTE_IDX_W-1:0]  note_d   [NUM_VOICES];
  logic [PERIOD_W-1:0]    period_q [NUM_VOICES];
  logic [PERIOD_W-1:0]    period_d [NUM_VOICES];

  logic [NUM_NOTES-1:0]   press_ev_c, release_ev_c;
  note_event_t            ev_c;
  logic [PERIOD_W-1:0]    sel_period_c;
  logic                   free_found_c;
  logic [VOICE_W-1:0]     free_voice_c, target_c, oldest_voice;
  logic                   alloc_en_c;
  logic                   dup_note_c;

  assign press_ev_c   = gate_q & ~ack_q;
  assign release_ev_c = ~gate_q & ack_q;
  assign busy         = |(gate_q ^ ack_q);

  // Event pick: any release beats any press, lowest note index first
  always_comb begin
    ev_c = '{kind: EV_NONE, note: '0};
    for (int unsigned n = 0; n < NUM_NOTES; n++) begin
      if (release_ev_c[n] && ev_c.kind == EV_NONE) ev_c = '{kind: EV_RELEASE, note: NOTE_IDX_W'(n)};
    end
    for (int unsigned n = 0; n < NUM_NOTES; n++) begin
      if (press_ev_c[n] && ev_c.kind == EV_NONE) ev_c = '{kind: EV_PRESS, note: NOTE_IDX_W'(n)};
    end
    sel_period_c = '0;
    for (int unsigned n = 0; n < NUM_NOTES; n++) begin
      if (NOTE_IDX_W'(n) == ev_c.note) sel_period_c = note_period[n*PERIOD_W +: PERIOD_W];
    end
  end

  always_comb begin
    free_found_c = 1'b0;
    free_voice_c = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!play_q[v] && !free_found_c) begin
        free_found_c = 1'b1;
        free_voice_c = VOICE_W'(v);
      end
    end
    target_c = free_found_c ? free_voice_c : oldest_voice;
  end

  always_comb begin
    ack_d      = ack_q;
    play_d     = play_q;
    note_d     = note_q;
    period_d   = period_q;
    trig_d     = '0;
    steal_d    = 1'b0;
    alloc_en_c = 1'b0;
    case (ev_c.kind)
      EV_RELEASE: begin
        for (int unsigned n = 0; n < NUM_NOTES; n++) begin
          if (NOTE_IDX_W'(n) == ev_c.note) ack_d[n] = 1'b0;
        end
        // A stolen note owns no voice, so this may match nothing
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (play_q[v] && note_q[v] == ev_c.note) play_d[v] = 1'b0;
        end
      end
      EV_PRESS: begin
        for (int unsigned n = 0; n < NUM_NOTES; n++) begin
          if (NOTE_IDX_W'(n) == ev_c.note) ack_d[n] = 1'b1;
        end
        play_d[target_c]   = 1'b1;
        note_d[target_c]   = ev_c.note;
        period_d[target_c] = sel_period_c;
        trig_d[target_c]   = 1'b1;
        steal_d            = ~free_found_c;
        alloc_en_c         = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gate_q  <= '0;
      ack_q   <= '0;
      play_q  <= '0;
      trig_q  <= '0;
      steal_q <= 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        note_q[v]   <= '0;
        period_q[v] <= '0;
      end
    end else begin
      gate_q   <= note_gate;
      ack_q    <= ack_d;
      play_q   <= play_d;
      trig_q   <= trig_d;
      steal_q  <= steal_d;
      note_q   <= note_d;
      period_q <= period_d;
    end
  end

  voice_age_tracker #(
    .NUM_VOICES(NUM_VOICES)
  ) u_age (
    .clock          (clock),
    .reset          (reset),
    .alloc_en_i     (alloc_en_c),
    .alloc_voice_i  (target_c),
    .oldest_voice_o (oldest_voice)
  );

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      voice_note[v*NOTE_IDX_W +: NOTE_IDX_W] = note_q[v];
      voice_period[v*PERIOD_W +: PERIOD_W]   = period_q[v];
    end
  end

  assign voice_play  = play_q;
  assign voice_trig  = trig_q;
  assign steal_pulse = steal_q;

  always_comb begin
    dup_note_c = 1'b0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      for (int unsigned w = v + 1; w < NUM_VOICES; w++) begin
        if (play_q[v] && play_q[w] && note_q[v] == note_q[w]) dup_note_c = 1'b1;
      end
    end
  end

  unique_notes: assert property (@(posedge clock) disable iff (reset) !dup_note_c);

endmodule

// File: tb/tb_voice_allocator.sv
// Directed test of voice_allocator: allocation latency, stealing, event
// priority, glitch rejection and reset recovery.
module tb_voice_allocator;
  import audio_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   note_gate = '0;
  logic [255:0] note_period;
  logic [3:0]   voice_play;
  logic [127:0] voice_period;
  logic [15:0]  voice_note;
  logic [3:0]   voice_trig;
  logic         steal_pulse;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;

  voice_allocator #(
    .NUM_NOTES(8), .NUM_VOICES(4), .PERIOD_W(32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .note_gate    (note_gate),
    .note_period  (note_period),
    .voice_play   (voice_play),
    .voice_period (voice_period),
    .voice_note   (voice_note),
    .voice_trig   (voice_trig),
    .steal_pulse  (steal_pulse),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] vn(input int v);
    return voice_note[v*4 +: 4];
  endfunction

  function automatic logic [31:0] vp(input int v);
    return voice_period[v*32 +: 32];
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    note_gate = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    note_period[0*32 +: 32] = 32'd191109;
    note_period[1*32 +: 32] = 32'd170265;
    note_period[2*32 +: 32] = 32'd151685;
    note_period[3*32 +: 32] = 32'd143172;
    note_period[4*32 +: 32] = 32'd127551;
    note_period[5*32 +: 32] = 32'd113636;
    note_period[6*32 +: 32] = 32'd101239;
    note_period[7*32 +: 32] = 32'd95556;

    // Reset state
    do_reset();
    check("rst_play",   128'(voice_play),   128'h0);
    check("rst_period", voice_period,       128'h0);
    check("rst_note",   128'(voice_note),   128'h0);
    check("rst_trig",   128'(voice_trig),   128'h0);
    check("rst_steal",  128'(steal_pulse),  128'h0);
    check("rst_busy",   128'(busy),         128'h0);

    // 1: single press of note 2, two-edge latency
    note_gate = 8'b0000_0100;
    tick();
    check("t1_busy_pend", 128'(busy),       128'h1);
    check("t1_play_pend", 128'(voice_play), 128'h0);
    tick();
    check("t1_play",   128'(voice_play),  128'h1);
    check("t1_note",   128'(vn(0)),       128'd2);
    check("t1_period", 128'(vp(0)),       128'd151685);
    check("t1_trig",   128'(voice_trig),  128'h1);
    check("t1_steal",  128'(steal_pulse), 128'h0);
    check("t1_busy",   128'(busy),        128'h0);
    tick();
    check("t1_trig_end", 128'(voice_trig), 128'h0);
    check("t1_play_hold", 128'(voice_play), 128'h1);

    // 2: fill all voices one at a time, fifth press steals voice 0
    do_reset();
    for (int n = 0; n < 4; n++) begin
      note_gate[n] = 1'b1;
      tick();
      tick();
    end
    check("t2_full_play", 128'(voice_play), 128'hF);
    check("t2_full_notes", 128'(voice_note), 128'h3210);
    note_gate[4] = 1'b1;
    tick();
    tick();
    check("t2_steal_play",   128'(voice_play),  128'hF);
    check("t2_steal_note",   128'(voice_note),  128'h3214);
    check("t2_steal_period", 128'(vp(0)),       128'd127551);
    check("t2_steal_pulse",  128'(steal_pulse), 128'h1);
    check("t2_steal_trig",   128'(voice_trig),  128'h1);
    tick();
    check("t2_steal_end", 128'(steal_pulse), 128'h0);
    note_gate[0] = 1'b0;
    tick();
    check("t2_rel_busy", 128'(busy), 128'h1);
    tick();
    check("t2_rel_play",  128'(voice_play), 128'hF);
    check("t2_rel_notes", 128'(voice_note), 128'h3214);
    check("t2_rel_trig",  128'(voice_trig), 128'h0);
    check("t2_rel_busy0", 128'(busy),       128'h0);

    // 3: notes 1,5,7 together, served on consecutive edges
    do_reset();
    note_gate = 8'b1010_0010;
    tick();
    check("t3_busy0", 128'(busy), 128'h1);
    tick();
    check("t3_trig_a", 128'(voice_trig), 128'h1);
    check("t3_note_a", 128'(vn(0)),      128'd1);
    check("t3_busy1",  128'(busy),       128'h1);
    tick();
    check("t3_trig_b", 128'(voice_trig), 128'h2);
    check("t3_note_b", 128'(vn(1)),      128'd5);
    check("t3_busy2",  128'(busy),       128'h1);
    tick();
    check("t3_trig_c",   128'(voice_trig), 128'h4);
    check("t3_note_c",   128'(vn(2)),      128'd7);
    check("t3_period_c", 128'(vp(2)),      128'd95556);
    check("t3_play",     128'(voice_play), 128'h7);
    check("t3_busy3",    128'(busy),       128'h0);

    // 4: release of note 0 and press of note 6 in the same cycle
    do_reset();
    note_gate = 8'b0000_1111;
    repeat (5) tick();
    check("t4_full", 128'(voice_note), 128'h3210);
    note_gate = 8'b0100_1110;
    tick();
    tick();
    check("t4_rel_play", 128'(voice_play), 128'hE);
    check("t4_rel_trig", 128'(voice_trig), 128'h0);
    tick();
    check("t4_new_play",   128'(voice_play),  128'hF);
    check("t4_new_note",   128'(vn(0)),       128'd6);
    check("t4_new_period", 128'(vp(0)),       128'd101239);
    check("t4_new_trig",   128'(voice_trig),  128'h1);
    check("t4_new_steal",  128'(steal_pulse), 128'h0);

    // 5: note 3 glitch while notes 0,1,2 are queued ahead of it
    do_reset();
    note_gate = 8'b0000_1111;
    tick();
    note_gate = 8'b0000_0111;
    tick();
    check("t5_trig_a", 128'(voice_trig), 128'h1);
    tick();
    check("t5_trig_b", 128'(voice_trig), 128'h2);
    tick();
    check("t5_trig_c", 128'(voice_trig), 128'h4);
    tick();
    check("t5_play", 128'(voice_play), 128'h7);
    check("t5_trig", 128'(voice_trig), 128'h0);
    check("t5_busy", 128'(busy),       128'h0);

    // 6: reset mid-play with notes 0,2 held
    do_reset();
    note_gate = 8'b0000_0101;
    repeat (3) tick();
    check("t6_pre_play",  128'(voice_play), 128'h3);
    check("t6_pre_notes", 128'(voice_note), 128'h0020);
    reset = 1'b1;
    tick();
    check("t6_rst_play",   128'(voice_play),  128'h0);
    check("t6_rst_note",   128'(voice_note),  128'h0);
    check("t6_rst_period", voice_period,      128'h0);
    check("t6_rst_busy",   128'(busy),        128'h0);
    check("t6_rst_trig",   128'(voice_trig),  128'h0);
    reset = 1'b0;
    tick();
    check("t6_pend_busy", 128'(busy),       128'h1);
    check("t6_pend_play", 128'(voice_play), 128'h0);
    tick();
    check("t6_a_play", 128'(voice_play), 128'h1);
    check("t6_a_note", 128'(vn(0)),      128'd0);
    check("t6_a_trig", 128'(voice_trig), 128'h1);
    tick();
    check("t6_b_play", 128'(voice_play), 128'h3);
    check("t6_b_note", 128'(vn(1)),      128'd2);
    check("t6_b_trig", 128'(voice_trig), 128'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
